axi2core: RTL and testbench

- AXI-Lite slave that bridges incoming single-beat AXI-Lite transactions onto a picorv32-style native memory bus (mem_valid/mem_ready handshake).
- It is the responder counterpart of the core-side AXI-Lite master bridge.
- It lets an external AXI-Lite master (DMA, Ethernet MAC, debug host) reach the core-local memory and native-bus peripherals.
- Provides one outstanding transaction, read/write arbitration, address decode and a ready timeout.

---
 rtl/axi2core.sv | 200 ++++++++++++++++++++
 tb/tb_axi2core.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2core.sv
// axi2core: AXI-Lite slave bridging single-beat transactions onto a
// picorv32-style native memory bus (mem_valid/mem_ready).
//
// Handshake rule for every AXI channel and the native bus: a transfer
// happens on a rising edge where valid && ready are both 1. A source that
// raises valid keeps valid and its payload stable until that edge. The
// native bus completes on mem_valid && mem_ready. Outstanding depth is one
// transaction per direction; AW/W/AR each own a one-entry holding register.
module axi2core #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] s_aw_addr,
  input  logic        s_aw_valid,
  output logic        s_aw_ready,
  input  logic [31:0] s_w_data,
  input  logic [3:0]  s_w_strb,
  input  logic        s_w_valid,
  output logic        s_w_ready,
  output logic [1:0]  s_b_resp,
  output logic        s_b_valid,
  input  logic        s_b_ready,
  input  logic [31:0] s_ar_addr,
  input  logic        s_ar_valid,
  output logic        s_ar_ready,
  output logic [31:0] s_r_data,
  output logic [1:0]  s_r_resp,
  output logic        s_r_valid,
  input  logic        s_r_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP} state_t;

  state_t      state, state_nx;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
  logic [3:0]  w_strb_q;
  logic        aw_full, w_full, ar_full, last_rd;
  logic [31:0] tcnt;
  logic        wr_pend, rd_pend, pick_wr, pick_rd;
  logic        wr_hit, rd_hit, wr_bus, in_req, bus_done, bus_tmo, b_hs, r_hs;

  assign s_aw_ready = !aw_full;
  assign s_w_ready  = !w_full;
  assign s_ar_ready = !ar_full;
  assign mem_instr  = 1'b0;
  assign dbg_state  = state;

  // Arbitration: a write needs both AW and W; on a tie, alternate using last_rd.
  assign wr_pend = aw_full && w_full;
  assign rd_pend = ar_full;
  assign pick_wr = (state == IDLE) && wr_pend && (!rd_pend || last_rd);
  assign pick_rd = (state == IDLE) && rd_pend && !(wr_pend && last_rd);

  // Decode; a hit write with no strobes is acknowledged without a bus cycle.
  assign wr_hit = (aw_addr_q & ADDR_MASK) == ADDR_BASE;
  assign rd_hit = (ar_addr_q & ADDR_MASK) == ADDR_BASE;
  assign wr_bus = wr_hit && (w_strb_q != 4'b0000);

  // mem_ready only counts while mem_valid is up; it also beats a same-edge timeout.
  assign in_req   = (state == WR_REQ) || (state == RD_REQ);
  assign bus_done = in_req && mem_valid && mem_ready;
  assign bus_tmo  = in_req && mem_valid && !mem_ready && (TIMEOUT != 0) &&
                    (tcnt == TIMEOUT - 1);
  assign b_hs     = s_b_valid && s_b_ready;
  assign r_hs     = s_r_valid && s_r_ready;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (pick_wr)      state_nx = wr_bus ? WR_REQ : WR_RESP;
        else if (pick_rd) state_nx = rd_hit ? RD_REQ : RD_RESP;
      end
      WR_REQ:  if (bus_done || bus_tmo) state_nx = WR_RESP;
      RD_REQ:  if (bus_done || bus_tmo) state_nx = RD_RESP;
      WR_RESP: if (b_hs) state_nx = IDLE;
      RD_RESP: if (r_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Channel holding registers and arbitration history.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_addr_q <= 32'h0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      ar_addr_q <= 32'h0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      ar_full   <= 1'b0;
      last_rd   <= 1'b0;
    end else begin
      if (s_aw_valid && s_aw_ready) begin
        aw_addr_q <= s_aw_addr;
        aw_full   <= 1'b1;
      end else if (b_hs) begin
        aw_full   <= 1'b0;
      end
      if (s_w_valid && s_w_ready) begin
        w_data_q <= s_w_data;
        w_strb_q <= s_w_strb;
        w_full   <= 1'b1;
      end else if (b_hs) begin
        w_full   <= 1'b0;
      end
      if (s_ar_valid && s_ar_ready) begin
        ar_addr_q <= s_ar_addr;
        ar_full   <= 1'b1;
      end else if (r_hs) begin
        ar_full   <= 1'b0;
      end
      if (pick_wr)      last_rd <= 1'b0;
      else if (pick_rd) last_rd <= 1'b1;
    end
  end

  // Native bus request: payload loads on selection, mem_valid rises one cycle later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      tcnt      <= 32'h0;
    end else begin
      if (pick_wr && wr_bus) begin
        mem_addr  <= {aw_addr_q[31:2], 2'b00};
        mem_wdata <= w_data_q;
        mem_wstrb <= w_strb_q;
      end else if (pick_rd && rd_hit) begin
        mem_addr  <= {ar_addr_q[31:2], 2'b00};
        mem_wdata <= 32'h0;
        mem_wstrb <= 4'h0;
      end
      if (bus_done || bus_tmo) mem_valid <= 1'b0;
      else if (in_req)         mem_valid <= 1'b1;
      if (in_req && mem_valid && !mem_ready && !bus_tmo) tcnt <= tcnt + 32'd1;
      else                                               tcnt <= 32'h0;
    end
  end

  // AXI responses: decode errors and empty writes answer straight from IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_b_valid <= 1'b0;
      s_b_resp  <= 2'b00;
      s_r_valid <= 1'b0;
      s_r_resp  <= 2'b00;
      s_r_data  <= 32'h0;
    end else begin
      if (pick_wr && !wr_bus) begin
        s_b_valid <= 1'b1;
        s_b_resp  <= wr_hit ? 2'b00 : 2'b11;
      end else if ((state == WR_REQ) && bus_done) begin
        s_b_valid <= 1'b1;
        s_b_resp  <= 2'b00;
      end else if ((state == WR_REQ) && bus_tmo) begin
        s_b_valid <= 1'b1;
        s_b_resp  <= 2'b10;
      end else if (b_hs) begin
        s_b_valid <= 1'b0;
      end
      if (pick_rd && !rd_hit) begin
        s_r_valid <= 1'b1;
        s_r_resp  <= 2'b11;
        s_r_data  <= 32'h0;
      end else if ((state == RD_REQ) && bus_done) begin
        s_r_valid <= 1'b1;
        s_r_resp  <= 2'b00;
        s_r_data  <= mem_rdata;
      end else if ((state == RD_REQ) && bus_tmo) begin
        s_r_valid <= 1'b1;
        s_r_resp  <= 2'b10;
        s_r_data  <= 32'h0;
      end else if (r_hs) begin
        s_r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi2core.sv
// Bench for axi2core: directed vector table, hand-written multi-cycle
// sequences and randomized single transactions against a word-memory model.
module tb_axi2core;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] s_aw_addr, s_w_data, s_ar_addr, s_r_data;
  logic        s_aw_valid, s_aw_ready, s_w_valid, s_w_ready;
  logic [3:0]  s_w_strb;
  logic [1:0]  s_b_resp, s_r_resp;
  logic        s_b_valid, s_b_ready, s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [2:0]  dbg_state;

  axi2core #(.ADDR_BASE(32'h0000_0000), .ADDR_MASK(32'hFFFF_0000), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic do_reset();
    resetn = 1'b0;
    s_aw_valid = 1'b0; s_w_valid = 1'b0; s_ar_valid = 1'b0;
    s_b_ready = 1'b0; s_r_ready = 1'b0;
    s_aw_addr = 32'h0; s_w_data = 32'h0; s_w_strb = 4'h0; s_ar_addr = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- native-bus responder (environment) ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  bus_t        bus_log[$];
  logic [31:0] bus_mem[logic [31:0]];
  int          mem_lat   = 0;
  bit          mem_stall = 1'b0;
  int          vcnt      = 0;
  int          hi_cnt    = 0;
  int          stab_err  = 0;
  bit          was_valid = 1'b0;
  bus_t        prev_bus;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return init_word(a);
  endfunction

  // Drive mem_ready/mem_rdata away from the active edge; watch payload stability.
  always @(negedge clk) begin
    if (mem_valid) begin
      hi_cnt++;
      vcnt++;
      if (was_valid && (prev_bus !== {mem_addr, mem_wdata, mem_wstrb})) stab_err++;
      prev_bus  = {mem_addr, mem_wdata, mem_wstrb};
      mem_ready = !mem_stall && (vcnt > mem_lat);
      mem_rdata = bus_rd(mem_addr);
    end else begin
      vcnt      = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
    end
    was_valid = mem_valid;
  end

  // Record completed native cycles and apply writes to the backing memory.
  always @(posedge clk) begin
    if (resetn && mem_valid && mem_ready) begin
      logic [31:0] w;
      bus_log.push_back({mem_addr, mem_wdata, mem_wstrb});
      if (mem_wstrb != 4'h0) begin
        w = bus_rd(mem_addr);
        for (int i = 0; i < 4; i++)
          if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
        bus_mem[mem_addr] = w;
      end
    end
  end

  // ---------------- reference model (AXI view) ----------------
  logic [31:0] ref_mem[logic [31:0]];
  logic [33:0] exp_q[$];

  function automatic bit ref_hit(input logic [31:0] a);
    return (a & 32'hFFFF_0000) == 32'h0000_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic void ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (!ref_hit(a) || s == 4'h0) return;
    w = ref_rd(a);
    for (int i = 0; i < 4; i++)
      if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    ref_mem[{a[31:2], 2'b00}] = w;
  endfunction

  // ---------------- drivers ----------------
  // Present a write, a read or both in the same cycle; wait for every response.
  task automatic txn(input bit wr, input bit rd, input logic [31:0] waddr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [31:0] raddr,
                     output logic [1:0] bresp, output logic [1:0] rresp, output logic [31:0] rdata,
                     output bit ok);
    bit aw_p, w_p, ar_p, b_p, r_p, haw, hw, har, hb, hr;
    int t;
    aw_p = wr; w_p = wr; ar_p = rd; b_p = wr; r_p = rd;
    bresp = 2'bxx; rresp = 2'bxx; rdata = 32'hx;
    @(negedge clk);
    s_aw_addr = waddr; s_w_data = wdata; s_w_strb = strb; s_ar_addr = raddr;
    s_aw_valid = aw_p; s_w_valid = w_p; s_ar_valid = ar_p;
    s_b_ready = 1'b1; s_r_ready = 1'b1;
    t = 0;
    while ((aw_p || w_p || ar_p || b_p || r_p) && t < 300) begin
      haw = s_aw_valid && s_aw_ready;
      hw  = s_w_valid && s_w_ready;
      har = s_ar_valid && s_ar_ready;
      hb  = b_p && s_b_valid;
      hr  = r_p && s_r_valid;
      if (hb) bresp = s_b_resp;
      if (hr) begin rresp = s_r_resp; rdata = s_r_data; end
      @(posedge clk); #1;
      if (haw) begin aw_p = 1'b0; s_aw_valid = 1'b0; end
      if (hw)  begin w_p  = 1'b0; s_w_valid  = 1'b0; end
      if (har) begin ar_p = 1'b0; s_ar_valid = 1'b0; end
      if (hb) b_p = 1'b0;
      if (hr) r_p = 1'b0;
      @(negedge clk);
      t++;
    end
    s_aw_valid = 1'b0; s_w_valid = 1'b0; s_ar_valid = 1'b0;
    s_b_ready = 1'b0; s_r_ready = 1'b0;
    ok = (t < 300);
  endtask

  // One transaction checked against the model plus expected resp / bus-cycle count.
  task automatic do_op(input string tag, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [1:0] er, input int eb);
    logic [1:0]  br, rr;
    logic [31:0] rdat, ed;
    logic [33:0] e;
    bit          ok;
    int          n0;
    bus_t        bl;
    ed = (!wr && ref_hit(addr)) ? ref_rd(addr) : 32'h0;
    exp_q.push_back({er, ed});
    n0 = bus_log.size();
    txn(wr, !wr, addr, data, strb, addr, br, rr, rdat, ok);
    check({tag, "_done"}, 64'(ok), 64'd1);
    e = exp_q.pop_front();
    if (wr) begin
      check({tag, "_bresp"}, 64'(br), 64'(e[33:32]));
    end else begin
      check({tag, "_rresp"}, 64'(rr), 64'(e[33:32]));
      check({tag, "_rdata"}, 64'(rdat), 64'(e[31:0]));
    end
    check({tag, "_buscnt"}, 64'(bus_log.size() - n0), 64'(eb));
    if (eb == 1 && bus_log.size() == n0 + 1) begin
      bl = bus_log[n0];
      check({tag, "_busaddr"}, 64'(bl.addr), 64'({addr[31:2], 2'b00}));
      check({tag, "_busstrb"}, 64'(bl.wstrb), 64'(wr ? strb : 4'h0));
      if (wr) check({tag, "_buswdata"}, 64'(bl.wdata), 64'(data));
    end
    if (wr) ref_wr(addr, data, strb);
  endtask

  // ---------------- test ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    int          exp_bus;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rdat;
    bit          ok;
    int          n0, t, bad;

    vecs[0] = '{1'b1, 32'h0000_1006, 32'hA5A5_1234, 4'b0011, 2'b00, 1};
    vecs[1] = '{1'b0, 32'h0000_1004, 32'h0,         4'b0000, 2'b00, 1};
    vecs[2] = '{1'b0, 32'h0001_0000, 32'h0,         4'b0000, 2'b11, 0};
    vecs[3] = '{1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 4'b0000, 2'b00, 0};
    vecs[4] = '{1'b1, 32'h0002_0000, 32'h1122_3344, 4'b1111, 2'b11, 0};
    vecs[5] = '{1'b0, 32'h0000_1008, 32'h0,         4'b0000, 2'b00, 1};
    vecs[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 2'b11, 0};
    vecs[7] = '{1'b1, 32'h0000_FFFC, 32'h8765_4321, 4'b1100, 2'b00, 1};
    vecs[8] = '{1'b0, 32'h0000_FFFF, 32'h0,         4'b0000, 2'b00, 1};

    do_reset();

    // Reset values.
    check("rst_readies", 64'({s_aw_ready, s_w_ready, s_ar_ready}), 64'h7);
    check("rst_valids", 64'({s_b_valid, s_r_valid, mem_valid}), 64'h0);
    check("rst_mem_out", 64'({mem_addr, mem_wstrb}), 64'h0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    check("rst_r_data", 64'(s_r_data), 64'h0);
    check("rst_resps", 64'({s_b_resp, s_r_resp}), 64'h0);
    check("mem_instr", 64'(mem_instr), 64'h0);

    // Directed table; first entry answers 2 cycles after mem_valid.
    for (int i = 0; i < 9; i++) begin
      mem_lat = (i == 0) ? 2 : i % 3;
      hi_cnt = 0;
      do_op($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
            vecs[i].exp_resp, vecs[i].exp_bus);
      if (i == 0) check("vec0_mem_valid_cycles", 64'(hi_cnt), 64'd3);
    end

    // W arrives 5 cycles ahead of AW.
    mem_lat = 1;
    n0 = bus_log.size();
    @(negedge clk);
    check("wlead_w_ready", 64'(s_w_ready), 64'd1);
    s_w_data = 32'h0BAD_CAFE; s_w_strb = 4'hF; s_w_valid = 1'b1;
    @(posedge clk); #1;
    s_w_valid = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_valid || s_w_ready || s_b_valid) bad++;
    end
    check("wlead_idle", 64'(bad), 64'd0);
    s_aw_addr = 32'h0000_1100; s_aw_valid = 1'b1;
    @(posedge clk); #1;
    s_aw_valid = 1'b0;
    s_b_ready = 1'b1;
    bad = 0; t = 0;
    @(negedge clk);
    while (!s_b_valid && t < 100) begin
      if (s_w_ready) bad++;
      @(negedge clk);
      t++;
    end
    check("wlead_bvalid", 64'(s_b_valid), 64'd1);
    check("wlead_wready_low", 64'({bad[30:0], s_w_ready}), 64'd0);
    check("wlead_bresp", 64'(s_b_resp), 64'd0);
    @(posedge clk); #1;
    s_b_ready = 1'b0;
    @(negedge clk);
    check("wlead_wready_back", 64'(s_w_ready), 64'd1);
    check("wlead_buscnt", 64'(bus_log.size() - n0), 64'd1);
    ref_wr(32'h0000_1100, 32'h0BAD_CAFE, 4'hF);
    do_op("wlead_readback", 1'b0, 32'h0000_1100, 32'h0, 4'h0, 2'b00, 1);

    // Read with r_ready withheld for 4 cycles.
    bus_mem[32'h0000_2000] = 32'hCAFE_F00D;
    ref_mem[32'h0000_2000] = 32'hCAFE_F00D;
    @(negedge clk);
    s_ar_addr = 32'h0000_2000; s_ar_valid = 1'b1; s_r_ready = 1'b0;
    @(posedge clk); #1;
    s_ar_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!s_r_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rhold_rvalid", 64'(s_r_valid), 64'd1);
    check("rhold_rdata", 64'(s_r_data), 64'(ref_rd(32'h0000_2000)));
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!s_r_valid || s_r_data !== 32'hCAFE_F00D || s_r_resp !== 2'b00) bad++;
    end
    check("rhold_stable", 64'(bad), 64'd0);
    s_r_ready = 1'b1;
    @(posedge clk); #1;
    s_r_ready = 1'b0;
    @(negedge clk);
    check("rhold_rvalid_drop", 64'(s_r_valid), 64'd0);

    // Timeout: mem_ready never comes.
    mem_stall = 1'b1;
    hi_cnt = 0;
    n0 = bus_log.size();
    txn(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0000_3000, br, rr, rdat, ok);
    check("tmo_done", 64'(ok), 64'd1);
    check("tmo_mem_valid_cycles", 64'(hi_cnt), 64'd8);
    check("tmo_rresp", 64'(rr), 64'h2);
    check("tmo_rdata", 64'(rdat), 64'h0);
    check("tmo_buscnt", 64'(bus_log.size() - n0), 64'd0);
    mem_stall = 1'b0;

    // Simultaneous write+read after reset: read first, then write; pairs repeat that order.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      logic [31:0] wa, ra, wd, er_d;
      wa = 32'h0000_1300 + 32'(p * 8);
      ra = wa + 32'h4;
      wd = $urandom;
      er_d = ref_rd(ra);
      mem_lat = p;
      n0 = bus_log.size();
      txn(1'b1, 1'b1, wa, wd, 4'hF, ra, br, rr, rdat, ok);
      check($sformatf("pair%0d_done", p), 64'(ok), 64'd1);
      check($sformatf("pair%0d_bresp", p), 64'(br), 64'h0);
      check($sformatf("pair%0d_rresp", p), 64'(rr), 64'h0);
      check($sformatf("pair%0d_rdata", p), 64'(rdat), 64'(er_d));
      check($sformatf("pair%0d_buscnt", p), 64'(bus_log.size() - n0), 64'd2);
      if (bus_log.size() >= n0 + 2) begin
        check($sformatf("pair%0d_first_is_read", p), 64'(bus_log[n0].wstrb), 64'h0);
        check($sformatf("pair%0d_second_is_write", p), 64'(bus_log[n0 + 1].wstrb), 64'hF);
      end
      ref_wr(wa, wd, 4'hF);
    end

    // Randomized single transactions.
    for (int i = 0; i < 40; i++) begin
      bit          wr, h;
      logic [31:0] a, d;
      logic [3:0]  s;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) a = $urandom | 32'h0001_0000;
      else a = 32'h0000_0100 + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      mem_lat = $urandom_range(0, 3);
      h = ref_hit(a);
      do_op($sformatf("rnd%0d", i), wr, a, d, s, h ? 2'b00 : 2'b11,
            (h && (!wr || s != 4'h0)) ? 1 : 0);
    end

    // Reset during an outstanding native request.
    mem_stall = 1'b1;
    @(negedge clk);
    s_aw_addr = 32'h0000_1200; s_w_data = 32'h5555_AAAA; s_w_strb = 4'hF;
    s_aw_valid = 1'b1; s_w_valid = 1'b1;
    @(posedge clk); #1;
    s_aw_valid = 1'b0; s_w_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!mem_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rstreq_mem_valid_up", 64'(mem_valid), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("rstreq_mem_valid_low", 64'(mem_valid), 64'd0);
    check("rstreq_readies_in_reset", 64'({s_aw_ready, s_w_ready, s_ar_ready}), 64'h7);
    @(negedge clk);
    resetn = 1'b1;
    mem_stall = 1'b0;
    @(negedge clk);
    check("rstreq_readies_after", 64'({s_aw_ready, s_w_ready, s_ar_ready}), 64'h7);
    check("rstreq_valids_after", 64'({s_b_valid, s_r_valid, mem_valid}), 64'h0);
    do_op("rstreq_after_read", 1'b0, 32'h0000_1200, 32'h0, 4'h0, 2'b00, 1);

    check("bus_payload_stable", 64'(stab_err), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
